// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: steers HPS ioctl download bytes into the program, char 1, char 2 and colour PROM regions,
// Latency: ioctl_wr -> rom_we/rom_sel/rom_addr/rom_data 1 cycle; core_reset registered from the next FSM state.
// Backpressure: none; every strobe is taken, so the ROM RAMs must accept one write per clk_sys cycle.
//
// Ports:
//   clk_sys, reset_n        clock, asynchronous active-low reset
//   ioctl_download/wr/...   hps_io download interface (flat byte address, byte data)
//   reset_req               level reset request from OSD / buttons
//   rom_sel/addr/data/we    registered one-hot region write to the ROM RAMs
//   core_reset              active-high reset to the core, held through load, check and settle
//   load_ok/load_err        result of the last download
//   byte_count/checksum     strobes seen and mod-2^16 sum of in-range bytes for the current/last download
module rom_load_sequencer #(
  parameter int PROG_SIZE     = 16384,
  parameter int CHR1_SIZE     = 4096,
  parameter int CHR2_SIZE     = 4096,
  parameter int PROM_SIZE     = 512,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        reset_req,
  output logic [3:0]  rom_sel,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_we,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  localparam int TOTAL = PROG_SIZE + CHR1_SIZE + CHR2_SIZE + PROM_SIZE;
  localparam logic [24:0] CHR1_BASE = 25'(PROG_SIZE);
  localparam logic [24:0] CHR2_BASE = 25'(PROG_SIZE + CHR1_SIZE);
  localparam logic [24:0] PROM_BASE = 25'(PROG_SIZE + CHR1_SIZE + CHR2_SIZE);
  localparam logic [24:0] TOTAL_A   = 25'(TOTAL);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_SETTLE, S_RUN, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0] settle_cnt;
  logic          oor;
  logic          load_entry, ok_set, err_set, core_reset_nxt;

  logic          wr_acc, in_range;
  logic [3:0]    dec_sel;
  logic [15:0]   dec_off;
  logic [16:0]   cnt_base, cnt_nxt;
  logic [15:0]   sum_base, sum_nxt;
  logic          oor_base, oor_nxt;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ioctl_download) state_nxt = S_LOAD;
      S_LOAD:   if (!ioctl_download) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (byte_count == 17'(TOTAL) && !oor) ? S_SETTLE : S_HALT;
      S_SETTLE: begin
        if (ioctl_download)                               state_nxt = S_LOAD;
        else if (!reset_req && settle_cnt == SETTLE_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        // A new download outranks a reset request.
        if (ioctl_download) state_nxt = S_LOAD;
        else if (reset_req) state_nxt = S_SETTLE;
      end
      S_HALT:   if (ioctl_download) state_nxt = S_LOAD;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode; everything here is registered below so outputs follow the transition by one cycle.
  always_comb begin
    core_reset_nxt = (state_nxt != S_RUN);
    load_entry     = (state_nxt == S_LOAD) && (state != S_LOAD);
    ok_set         = (state == S_CHECK) && (state_nxt == S_SETTLE);
    err_set        = (state == S_CHECK) && (state_nxt == S_HALT);
  end

  // A strobe in the cycle ioctl_download drops still belongs to the download, so LOAD also accepts it.
  always_comb begin
    wr_acc   = ioctl_wr && (ioctl_download || state == S_LOAD);
    in_range = (ioctl_addr < TOTAL_A);
    dec_sel  = 4'b0000;
    dec_off  = 16'd0;
    if (ioctl_addr < CHR1_BASE) begin
      dec_sel = 4'b0001;
      dec_off = 16'(ioctl_addr);
    end else if (ioctl_addr < CHR2_BASE) begin
      dec_sel = 4'b0010;
      dec_off = 16'(ioctl_addr - CHR1_BASE);
    end else if (ioctl_addr < PROM_BASE) begin
      dec_sel = 4'b0100;
      dec_off = 16'(ioctl_addr - CHR2_BASE);
    end else if (in_range) begin
      dec_sel = 4'b1000;
      dec_off = 16'(ioctl_addr - PROM_BASE);
    end
  end

  // Statistics restart on LOAD entry; the entry cycle's own strobe is added on top of the cleared value.
  always_comb begin
    cnt_base = load_entry ? 17'd0 : byte_count;
    sum_base = load_entry ? 16'd0 : checksum;
    oor_base = load_entry ? 1'b0  : oor;
    cnt_nxt  = (wr_acc && cnt_base != '1) ? cnt_base + 17'd1 : cnt_base;
    sum_nxt  = (wr_acc && in_range) ? sum_base + {8'h00, ioctl_dout} : sum_base;
    oor_nxt  = oor_base | (wr_acc && !in_range);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_we     <= 1'b0;
      rom_sel    <= 4'b0000;
      rom_addr   <= 16'd0;
      rom_data   <= 8'd0;
      byte_count <= 17'd0;
      checksum   <= 16'd0;
      oor        <= 1'b0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      core_reset <= 1'b1;
      settle_cnt <= '0;
    end else begin
      rom_we     <= wr_acc && in_range;
      rom_sel    <= (wr_acc && in_range) ? dec_sel : 4'b0000;
      if (wr_acc && in_range) begin
        rom_addr <= dec_off;
        rom_data <= ioctl_dout;
      end
      byte_count <= cnt_nxt;
      checksum   <= sum_nxt;
      oor        <= oor_nxt;
      load_ok    <= load_entry ? 1'b0 : (ok_set  ? 1'b1 : load_ok);
      load_err   <= load_entry ? 1'b0 : (err_set ? 1'b1 : load_err);
      core_reset <= core_reset_nxt;
      // Counts only while settling undisturbed; a reset request or leaving SETTLE restarts from zero.
      settle_cnt <= (state == S_SETTLE && state_nxt == S_SETTLE && !reset_req) ? settle_cnt + SW'(1) : '0;
    end
  end

endmodule
